// File: rtl/data_sync_ctrl.sv
// Destination-side controller for a toggle-handshake multi-bit synchronizer.
// Optional macro DSC_INT_SYNC_EN adds NUM_STAGES internal synchronizer flops on REQ_TOG.
module data_sync_ctrl #(
  parameter int BUS_WIDTH  = 8,
  parameter int NUM_STAGES = 2,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 REQ_TOG,
  input  logic [BUS_WIDTH-1:0] UNSYNC_BUS,
  input  logic                 DST_READY,
  input  logic                 CLR_ERR,
  output logic [BUS_WIDTH-1:0] SYNC_BUS,
  output logic                 DATA_VALID,
  output logic                 ENABLE_PULSE,
  output logic                 ACK_TOG,
  output logic                 BUSY,
  output logic                 OVERRUN,
  output logic [CNT_WIDTH-1:0] XFER_CNT
);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t state;
  logic   req_s;
  logic   req_prev;
  logic   req_edge;

  if (NUM_STAGES < 2) begin : g_stage_chk
    $error("data_sync_ctrl: NUM_STAGES must be >= 2");
  end

`ifdef DSC_INT_SYNC_EN
  logic [NUM_STAGES-1:0] sync_pipe;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) sync_pipe <= '0;
    else      sync_pipe <= {sync_pipe[NUM_STAGES-2:0], REQ_TOG};
  end

  assign req_s = sync_pipe[NUM_STAGES-1];
`else
  assign req_s = REQ_TOG;
`endif

  assign req_edge = req_s ^ req_prev;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state        <= IDLE;
      req_prev     <= 1'b0;
      SYNC_BUS     <= '0;
      DATA_VALID   <= 1'b0;
      ENABLE_PULSE <= 1'b0;
      ACK_TOG      <= 1'b0;
      BUSY         <= 1'b0;
      OVERRUN      <= 1'b0;
      XFER_CNT     <= '0;
    end else begin
      req_prev     <= req_s;
      ENABLE_PULSE <= 1'b0;
      // A toggle while the previous word is still held is dropped; set beats clear.
      if (state == HOLD && req_edge) OVERRUN <= 1'b1;
      else if (CLR_ERR)              OVERRUN <= 1'b0;
      case (state)
        IDLE: begin
          if (req_edge) begin
            SYNC_BUS     <= UNSYNC_BUS;
            DATA_VALID   <= 1'b1;
            ENABLE_PULSE <= 1'b1;
            BUSY         <= 1'b1;
            state        <= HOLD;
          end
        end
        HOLD: begin
          if (DST_READY) begin
            ACK_TOG    <= ~ACK_TOG;
            DATA_VALID <= 1'b0;
            BUSY       <= 1'b0;
            XFER_CNT   <= XFER_CNT + 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_sync_ctrl.sv
// Scoreboard bench for data_sync_ctrl: the driver acts as the source and consumer,
// a negedge monitor checks every capture against the queued expectation.
module tb_data_sync_ctrl;
  localparam int BW = 8;
  localparam int CW = 8;
  localparam int NS = 3;
`ifdef DSC_INT_SYNC_EN
  localparam int LAT = NS + 1;
`else
  localparam int LAT = 1;
`endif

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          REQ_TOG = 1'b0;
  logic          DST_READY = 1'b0;
  logic          CLR_ERR = 1'b0;
  logic [BW-1:0] UNSYNC_BUS = '0;
  logic [BW-1:0] SYNC_BUS;
  logic          DATA_VALID, ENABLE_PULSE, ACK_TOG, BUSY, OVERRUN;
  logic [CW-1:0] XFER_CNT;

  data_sync_ctrl #(.BUS_WIDTH(BW), .NUM_STAGES(NS), .CNT_WIDTH(CW)) dut (
    .CLK(CLK), .RST(RST), .REQ_TOG(REQ_TOG), .UNSYNC_BUS(UNSYNC_BUS),
    .DST_READY(DST_READY), .CLR_ERR(CLR_ERR), .SYNC_BUS(SYNC_BUS),
    .DATA_VALID(DATA_VALID), .ENABLE_PULSE(ENABLE_PULSE), .ACK_TOG(ACK_TOG),
    .BUSY(BUSY), .OVERRUN(OVERRUN), .XFER_CNT(XFER_CNT)
  );

  always #5 CLK = ~CLK;

  typedef struct { logic [BW-1:0] data; int cnt; } exp_t;
  exp_t exp_q[$];

  int   n_cmp = 0;
  int   n_bad = 0;
  int   model_cnt = 0;
  logic model_ack = 1'b0;
  logic exp_ovr = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: each capture strobe must match the oldest outstanding request.
  always @(negedge CLK) begin
    if (RST && ENABLE_PULSE) begin
      exp_t e;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_capture: got bus %0h with no request outstanding at %0t", SYNC_BUS, $time);
      end else begin
        e = exp_q.pop_front();
        chk("capture_data", 32'(SYNC_BUS), 32'(e.data));
        chk("capture_cnt", 32'(XFER_CNT), 32'(e.cnt % (1 << CW)));
        chk("capture_valid_busy", {30'd0, DATA_VALID, BUSY}, 32'd3);
      end
    end
  end

  // One source transaction: toggle, wait capture, hold dly cycles, then accept.
  // ovr=1 injects a toggle during HOLD; ovr=2 also pulses CLR_ERR on the same edge.
  task automatic xfer(input logic [BW-1:0] d, input int dly, input int ovr);
    int   k;
    exp_t e;
    e.data = d;
    e.cnt  = model_cnt;
    exp_q.push_back(e);
    UNSYNC_BUS = d;
    DST_READY  = (dly == 0);
    REQ_TOG    = ~REQ_TOG;
    k = 0;
    do begin
      @(negedge CLK);
      k++;
    end while (!DATA_VALID && k < 40);
    chk("capture_latency", 32'(k), 32'(LAT));
    if (!DATA_VALID) return;
    for (int j = 0; j < dly; j++) begin
      if (j > 0) begin
        @(negedge CLK);
        chk("hold_state", {21'd0, DATA_VALID, BUSY, ENABLE_PULSE, SYNC_BUS}, {21'd0, 3'b110, d});
      end
      if (ovr != 0 && j == 0) begin
        UNSYNC_BUS = 8'h3C;
        REQ_TOG    = ~REQ_TOG;
        exp_ovr    = 1'b1;
      end
      CLR_ERR = (ovr == 2 && j == LAT - 1);
    end
    DST_READY = 1'b1;
    @(negedge CLK);
    CLR_ERR = 1'b0;
    model_cnt++;
    model_ack = ~model_ack;
    chk("done_valid_busy", {30'd0, DATA_VALID, BUSY}, 32'd0);
    chk("ack_tog", {31'd0, ACK_TOG}, {31'd0, model_ack});
    chk("xfer_cnt", 32'(XFER_CNT), 32'(model_cnt % (1 << CW)));
    chk("overrun", {31'd0, OVERRUN}, {31'd0, exp_ovr});
    chk("sync_bus_kept", 32'(SYNC_BUS), 32'(d));
  endtask

  task automatic clr_err();
    CLR_ERR = 1'b1;
    @(negedge CLK);
    CLR_ERR = 1'b0;
    exp_ovr = 1'b0;
    chk("overrun_clear", {31'd0, OVERRUN}, {31'd0, exp_ovr});
  endtask

  task automatic rst_mid_hold();
    int   k;
    exp_t e;
    e.data = 8'h77;
    e.cnt  = model_cnt;
    exp_q.push_back(e);
    UNSYNC_BUS = 8'h77;
    DST_READY  = 1'b0;
    REQ_TOG    = ~REQ_TOG;
    k = 0;
    do begin
      @(negedge CLK);
      k++;
    end while (!DATA_VALID && k < 40);
    chk("rst_capture_seen", {31'd0, DATA_VALID}, 32'd1);
    @(negedge CLK);
    #2 RST = 1'b0;
    #1 chk("rst_async_clear", {11'd0, SYNC_BUS, DATA_VALID, ENABLE_PULSE, ACK_TOG, BUSY, OVERRUN, XFER_CNT}, 32'd0);
    REQ_TOG   = 1'b0;
    model_cnt = 0;
    model_ack = 1'b0;
    exp_ovr   = 1'b0;
    exp_q.delete();
    @(negedge CLK);
    RST = 1'b1;
  endtask

  initial begin
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      chk("idle_after_reset", {11'd0, SYNC_BUS, DATA_VALID, ENABLE_PULSE, ACK_TOG, BUSY, OVERRUN, XFER_CNT}, 32'd0);
    end

    xfer(8'hA5, 0, 0);
    xfer(8'hA5, 5, 0);
    xfer(8'hA5, LAT + 3, 1);
    clr_err();
    xfer(8'h5A, LAT + 2, 2);
    xfer(8'hC3, 1, 0);
    rst_mid_hold();

    for (int i = 0; i < 256; i++) xfer(8'(i), 0, 0);
    chk("wrap_cnt", 32'(XFER_CNT), 32'd0);
    chk("wrap_ack", {31'd0, ACK_TOG}, 32'd0);

    for (int i = 0; i < 40; i++) begin
      logic [BW-1:0] d;
      int            ovr;
      int            dly;
      d   = 8'($urandom);
      ovr = ($urandom_range(0, 3) == 0) ? 1 : 0;
      dly = (ovr != 0) ? LAT + 1 + int'($urandom_range(0, 2)) : int'($urandom_range(0, 3));
      xfer(d, dly, ovr);
      if (exp_ovr && $urandom_range(0, 1) == 1) clr_err();
    end

    DST_READY = 1'b0;
    repeat (LAT + 3) @(negedge CLK);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/data_sync_ctrl.md
Name: data_sync_ctrl

Overview:
- Destination-domain controller for a toggle-handshake multi-bit synchronizer.
- Watches a request toggle from the source domain. The toggle arrives through a bit synchronizer, or optionally through internal stages.
- On a new request: captures the quasi-static source bus, presents it to the local consumer with valid/ready, and returns an acknowledge toggle to the source once the data has been consumed.
- Flags protocol overruns and counts completed transfers. Sits between the bit-synchronizer path and destination-domain logic in the multi-clock system.

Parameters:
- BUS_WIDTH, 8, width of the transferred data bus.
- NUM_STAGES, 2, internal synchronizer depth on REQ_TOG; used only when DSC_INT_SYNC_EN is defined; must be >= 2.
- CNT_WIDTH, 8, width of the completed-transfer counter.

Ports:
- CLK  in  1  destination-domain clock.
- RST  in  1  asynchronous active-low reset.
- REQ_TOG  in  1  request toggle from the source domain; each level change means new data.
- UNSYNC_BUS  in  BUS_WIDTH  source data; held stable by the source from toggle until ACK_TOG is seen.
- DST_READY  in  1  consumer accepts the data this cycle.
- CLR_ERR  in  1  clears OVERRUN.
- SYNC_BUS  out  BUS_WIDTH  captured data, registered.
- DATA_VALID  out  1  SYNC_BUS holds unconsumed data.
- ENABLE_PULSE  out  1  one-cycle strobe in the capture cycle.
- ACK_TOG  out  1  acknowledge toggle back to the source.
- BUSY  out  1  high while in HOLD.
- OVERRUN  out  1  sticky protocol-violation flag.
- XFER_CNT  out  CNT_WIDTH  completed transfers, wraps modulo 2^CNT_WIDTH.

Behaviour:
- Reset (RST low, async): all outputs 0; internal req_prev = 0; sync stages = 0; state = IDLE. Reset mid-transfer discards held data and returns ACK_TOG to 0. The source must be reset together with this block.
- req_s: REQ_TOG directly without the macro; last internal sync stage with it. Edge detect: edge = req_s XOR req_prev. req_prev <= req_s every cycle.
- IDLE, edge=1:
  - SYNC_BUS <= UNSYNC_BUS.
  - DATA_VALID <= 1; ENABLE_PULSE <= 1 for exactly one cycle; BUSY <= 1.
  - Go to HOLD.
- IDLE, edge=0: outputs hold; DATA_VALID = 0.
- HOLD: SYNC_BUS frozen; DATA_VALID = 1; ENABLE_PULSE = 0.
  - On DST_READY=1 (sampled at a clock edge): ACK_TOG <= ~ACK_TOG; DATA_VALID <= 0; BUSY <= 0; XFER_CNT <= XFER_CNT+1; go to IDLE.
  - DST_READY is ignored in IDLE.
- Earliest DST_READY that counts is in the first HOLD cycle, i.e. the cycle ENABLE_PULSE is high. Minimum occupancy is therefore 1 cycle in HOLD.
- Latency:
  - Without macro: first rising CLK edge at which REQ_TOG is seen changed updates SYNC_BUS, DATA_VALID and ENABLE_PULSE at that edge (1-cycle registered).
  - With macro: NUM_STAGES additional cycles.
- Back-to-back: after return to IDLE, a new edge the very next cycle is captured normally. No dead cycle.
- Overrun:
  - Trigger: edge=1 while in HOLD, including the same cycle as DST_READY.
  - Response: OVERRUN <= 1; the new data is dropped (not captured); req_prev still tracks req_s. The current transfer continues unaffected.
  - CLR_ERR clears OVERRUN. If set and clear occur in the same cycle, set wins.
- XFER_CNT wraps 2^CNT_WIDTH-1 -> 0 without any flag.
- Source-side rule (documented, not checked): do not change UNSYNC_BUS or toggle REQ_TOG until ACK_TOG has been synchronized back.

Optional Feature:
- Macro: DSC_INT_SYNC_EN.
- Defined: REQ_TOG passes through NUM_STAGES internal reset-to-0 flip-flops before edge detection. The block is safe to connect directly to the source domain. Capture latency is NUM_STAGES+1 cycles from the REQ_TOG change.
- Undefined: no internal stages; REQ_TOG must already be synchronized externally by the bit-synchronizer block. Latency is 1 cycle.

Test Plan:
- Reset release, REQ_TOG=0, idle 10 cycles -> all outputs 0, no ENABLE_PULSE.
- UNSYNC_BUS=8'hA5, REQ_TOG 0->1, DST_READY=1 constant -> SYNC_BUS=8'hA5, ENABLE_PULSE exactly 1 cycle, DATA_VALID 1 cycle, ACK_TOG 0->1, XFER_CNT=1.
- Same, but DST_READY held 0 for 5 cycles then 1 -> DATA_VALID and BUSY high 5 cycles, SYNC_BUS stable at 8'hA5, ACK_TOG toggles one cycle after DST_READY sampled.
- REQ_TOG toggles again while in HOLD with bus 8'h3C -> OVERRUN=1, SYNC_BUS stays 8'hA5, XFER_CNT increments once only. Then CLR_ERR=1 -> OVERRUN=0. CLR_ERR together with a new violation -> OVERRUN stays 1.
- 256 back-to-back transfers, values 0..255, CNT_WIDTH=8 -> every value captured in order, XFER_CNT wraps to 0, ACK_TOG ends at 0.
- RST asserted mid-HOLD -> DATA_VALID, ACK_TOG, XFER_CNT, SYNC_BUS immediately 0. With DSC_INT_SYNC_EN, NUM_STAGES=3: capture occurs exactly 4 cycles after the REQ_TOG change.
